// File: rtl/rr_arb2x1_pkg.sv
// Shared types and the round-robin pick function for the 2:1 arbiter.
package rr_arb2x1_pkg;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_e;

    // Lone requester wins; on a tie the one not granted last time wins.
    function automatic src_e rr_pick(input logic v0, input logic v1, input src_e last);
        if (v0 && v1) begin
            return (last == SRC0) ? SRC1 : SRC0;
        end else if (v1) begin
            return SRC1;
        end else begin
            return SRC0;
        end
    endfunction

endpackage

// File: rtl/rr_arb2x1_mux.sv
// WIDTH-wide 2:1 multiplexer used as the arbiter payload select.
module mux2x1_w #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = sel_i ? b_i : a_i;
    end

endmodule

// File: rtl/rr_arb2x1.sv
// Two-requester round-robin arbiter feeding a single registered output slot.
module rr_arb2x1
    import rr_arb2x1_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    src_e             out_src_q,   out_src_d;
    src_e             last_q,      last_d;

    src_e             grant;
    logic             slot_free;
    logic             take;
    logic             accept;
    logic [WIDTH-1:0] mux_y;

    // Slot frees when empty or draining this cycle, allowing drain+refill.
    always_comb begin
        grant     = rr_pick(in0_valid, in1_valid, last_q);
        slot_free = ~out_valid_q | out_ready;
        take      = ~rst & slot_free;
        in0_ready = take & in0_valid & (grant == SRC0);
        in1_ready = take & in1_valid & (grant == SRC1);
        accept    = (in0_valid & in0_ready) | (in1_valid & in1_ready);
    end

    mux2x1_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel_i (grant == SRC1),
        .a_i   (in0_data),
        .b_i   (in1_data),
        .y_o   (mux_y)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        last_d      = last_q;
        if (slot_free) begin
            out_valid_d = accept;
            if (accept) begin
                out_data_d = mux_y;
                out_src_d  = grant;
                last_d     = grant;
            end
        end
    end

    // Reset leaves last grant at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC0;
            last_q      <= SRC1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: doc/rr_arb2x1.md
RR_ARB2X1 -- requirements
Module: rr_arb2x1

Interface
REQ-001 Parameter WIDTH, default 8, data width of each requester and of the output channel.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in0_valid  input  1  requester 0 has data.
REQ-005 in0_data  input  WIDTH  requester 0 payload.
REQ-006 in0_ready  output  1  requester 0 payload accepted this cycle.
REQ-007 in1_valid  input  1  requester 1 has data.
REQ-008 in1_data  input  WIDTH  requester 1 payload.
REQ-009 in1_ready  output  1  requester 1 payload accepted this cycle.
REQ-010 out_valid  output  1  output register holds a beat.
REQ-011 out_data  output  WIDTH  registered payload of the granted requester.
REQ-012 out_src  output  1  index of the requester that supplied out_data.
REQ-013 out_ready  input  1  downstream accepts the beat.

Function
REQ-014 Transfer on any channel SHALL occur only when its valid and ready are both high at a rising edge.
REQ-015 The output slot SHALL be free when out_valid=0 or out_ready=1 (a free slot permits same-cycle drain and refill).
REQ-016 in0_ready and in1_ready SHALL be combinational: high only for the granted requester and only when the slot is free; never both high.
REQ-017 Grant SHALL go to the only valid requester, or, if both are valid, to the requester not equal to last_grant.
REQ-018 last_grant SHALL update to the granted index only on an accepted input transfer.
REQ-019 Datapath selection SHALL be a 2:1 mux whose select is the grant index.
REQ-020 Latency SHALL be 1 cycle: an input accepted at edge N gives out_valid=1 with out_data/out_src valid after edge N.
REQ-021 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_src SHALL hold stable and both in*_ready SHALL be 0.
REQ-023 out_valid SHALL fall after an edge with out_ready=1 and no accepted input.
REQ-024 Neither requester SHALL wait more than one accepted beat of the other while continuously valid (fairness bound).
REQ-025 A requester dropping valid before acceptance SHALL forfeit nothing; arbitration is re-evaluated every cycle.
REQ-026 Payload SHALL pass unmodified; no width conversion or arithmetic.

Reset
REQ-027 On rst=1 at a rising edge: out_valid=0, out_data=0, out_src=0, last_grant=1 (requester 0 wins the first tie).
REQ-028 in0_ready and in1_ready SHALL be 0 during any cycle with rst=1.
REQ-029 Reset mid-operation SHALL discard a held output beat; no beat SHALL be emitted after release without a new input transfer.

Structure
REQ-030 No shared package is required; WIDTH is the only configuration constant and stays a module parameter.
REQ-031 The datapath select SHALL instantiate the existing mux2x1 per bit (or a WIDTH-wide mux2 sub-module named mux2x1_w); arbitration and the output register live in rr_arb2x1.
REQ-032 Implementation SHALL be a single always block for registered state plus combinational grant logic; no latches.

Verification
REQ-033 Reset: hold rst=1 two cycles with both valid -> out_valid=0, out_data=0, in0_ready=in1_ready=0.
REQ-034 Single requester: in0_valid=1, in0_data=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_src=0.
REQ-035 Contention: both valid continuously, in0_data=8'h11, in1_data=8'h22, out_ready=1 -> out_src sequence 0,1,0,1 and out_data 11,22,11,22.
REQ-036 Backpressure: beat 8'h3C held, out_ready=0 for 5 cycles -> out_data stays 8'h3C, both in*_ready=0; on out_ready=1 the next beat loads the same cycle.
REQ-037 Reset mid-stall: out_valid=1 with out_ready=0, assert rst one cycle -> out_valid=0 afterwards; first tie goes to requester 0.
REQ-038 Randomized 1000 cycles with $random valids/out_ready -> scoreboard per source matches in order, no loss or duplication, fairness bound REQ-024 never violated.
